// File: rtl/vga_timing_pkg.sv
`timescale 1ns/1ps
// vga_timing_pkg
// Shared 640x480@60 VGA timing constants for the RTC display pipeline.
// The sync generator and the overlay stages (digits, date bars, hour
// separators) all take their visible extents and sync windows from here.
package vga_timing_pkg;

    localparam int unsigned COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    localparam int unsigned H_DISPLAY = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;

    localparam int unsigned V_DISPLAY = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    // Inclusive sync windows, in pixel / line coordinates.
    localparam int unsigned HSYNC_START = H_DISPLAY + H_FRONT;
    localparam int unsigned HSYNC_END   = H_DISPLAY + H_FRONT + H_SYNC - 1;
    localparam int unsigned VSYNC_START = V_DISPLAY + V_FRONT;
    localparam int unsigned VSYNC_END   = V_DISPLAY + V_FRONT + V_SYNC - 1;

endpackage

// File: rtl/pixel_tick_gen.sv
`timescale 1ns/1ps
// pixel_tick_gen
// Divides clk into a one-clk pixel enable every CLK_DIV clks (CLK_DIV >= 2).
// Ports:
//   clk    - system clock
//   reset  - synchronous, active-high; clears the divider
//   p_tick - high for one clk when the divider is at its last count
module pixel_tick_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] d_q;
    logic [DW-1:0] d_d;

    always_comb begin
        d_d = d_q + DW'(1);
        if (d_q == D_LAST) begin
            d_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d_q <= '0;
        end else begin
            d_q <= d_d;
        end
    end

    // Decoded from the register so the enable is glitch-free and a reset
    // clk always reads as "no tick".
    assign p_tick = (d_q == D_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
`timescale 1ns/1ps
// vga_sync_gen
// VGA timing generator: pixel-rate enable plus horizontal/vertical counters
// with registered video_on, hsync, vsync and frame_start decode.
// Ports:
//   clk, reset   - system clock; synchronous active-high reset
//   p_tick       - pixel enable, one clk every CLK_DIV clks
//   pix_x, pix_y - current pixel / line counts
//   video_on     - inside the visible area
//   hsync, vsync - active-low sync pulses
//   frame_start  - one-clk pulse when the counts become (0,0)
module vga_sync_gen
    import vga_timing_pkg::COORD_W;
    import vga_timing_pkg::coord_t;
#(
    parameter int unsigned H_DISPLAY = vga_timing_pkg::H_DISPLAY,
    parameter int unsigned H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int unsigned H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BACK    = vga_timing_pkg::H_BACK,
    parameter int unsigned V_DISPLAY = vga_timing_pkg::V_DISPLAY,
    parameter int unsigned V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int unsigned V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BACK    = vga_timing_pkg::V_BACK,
    parameter int unsigned CLK_DIV   = 4
) (
    input  logic               clk,
    input  logic               reset,
    output logic               p_tick,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               video_on,
    output logic               hsync,
    output logic               vsync,
    output logic               frame_start
);

    localparam int unsigned H_LINE  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_FRAME = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t X_LAST   = coord_t'(H_LINE - 1);
    localparam coord_t Y_LAST   = coord_t'(V_FRAME - 1);
    localparam coord_t X_VIS    = coord_t'(H_DISPLAY);
    localparam coord_t Y_VIS    = coord_t'(V_DISPLAY);
    localparam coord_t HS_FIRST = coord_t'(H_DISPLAY + H_FRONT);
    localparam coord_t HS_LAST  = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam coord_t VS_FIRST = coord_t'(V_DISPLAY + V_FRONT);
    localparam coord_t VS_LAST  = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    coord_t x_q, x_d;
    coord_t y_q, y_d;
    logic   video_on_q, video_on_d;
    logic   hsync_q, hsync_d;
    logic   vsync_q, vsync_d;
    logic   frame_start_q, frame_start_d;

    pixel_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_pixel_tick_gen (
        .clk   (clk),
        .reset (reset),
        .p_tick(p_tick)
    );

    // Decode is taken from the next counts so the registered flags change on
    // the same edge as pix_x/pix_y (zero latency between counts and flags).
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (p_tick) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + coord_t'(1);
            end else begin
                x_d = x_q + coord_t'(1);
            end
        end
        video_on_d    = (x_d < X_VIS) && (y_d < Y_VIS);
        hsync_d       = !((x_d >= HS_FIRST) && (x_d <= HS_LAST));
        vsync_d       = !((y_d >= VS_FIRST) && (y_d <= VS_LAST));
        frame_start_d = p_tick && (x_d == '0) && (y_d == '0);
    end

    // Counts reset to the last pixel of the frame so the first tick after
    // reset lands cleanly on (0,0).
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q           <= X_LAST;
            y_q           <= Y_LAST;
            video_on_q    <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            video_on_q    <= video_on_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pix_x       = x_q;
    assign pix_y       = y_q;
    assign video_on    = video_on_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
`timescale 1ns/1ps
// tb_vga_sync_gen
// Scoreboard bench: drivers push the expected post-edge outputs, computed
// from clks-since-reset by closed-form timing arithmetic; monitors pop and
// compare after every edge. Instance A uses default 640x480 timing, instance
// B a tiny 8/2/2/2 x 4/1/1/1 frame with CLK_DIV=2 for full-frame coverage.
module tb_vga_sync_gen;

    typedef struct packed {
        logic       p_tick;
        logic [9:0] x;
        logic [9:0] y;
        logic       video_on;
        logic       hsync;
        logic       vsync;
        logic       frame_start;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b1, rst_b = 1'b1;
    logic       pt_a, von_a, hs_a, vs_a, fs_a;
    logic       pt_b, von_b, hs_b, vs_b, fs_b;
    logic [9:0] x_a, y_a, x_b, y_b;

    obs_t q_a[$];
    obs_t q_b[$];

    int n_checks = 0;
    int n_pass   = 0;

    vga_sync_gen u_dut_a (
        .clk(clk), .reset(rst_a), .p_tick(pt_a), .pix_x(x_a), .pix_y(y_a),
        .video_on(von_a), .hsync(hs_a), .vsync(vs_a), .frame_start(fs_a)
    );

    vga_sync_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .CLK_DIV(2)
    ) u_dut_b (
        .clk(clk), .reset(rst_b), .p_tick(pt_b), .pix_x(x_b), .pix_y(y_b),
        .video_on(von_b), .hsync(hs_b), .vsync(vs_b), .frame_start(fs_b)
    );

    // e = clk edges since reset released (0 while in reset). Ticks consumed
    // so far = e/div; the first consumed tick is pixel 0 of the frame.
    function automatic obs_t model(input int e, input int div,
                                   input int hd, input int hf, input int hs, input int hb,
                                   input int vd, input int vf, input int vs, input int vb);
        obs_t o;
        int ht, vt, t, p, x, y;
        ht = hd + hf + hs + hb;
        vt = vd + vf + vs + vb;
        t  = e / div;
        o.p_tick = ((e % div) == div - 1);
        if (t == 0) begin
            x = ht - 1;
            y = vt - 1;
            o.video_on    = 1'b0;
            o.hsync       = 1'b1;
            o.vsync       = 1'b1;
            o.frame_start = 1'b0;
        end else begin
            p = (t - 1) % (ht * vt);
            x = p % ht;
            y = p / ht;
            o.video_on    = (x < hd) && (y < vd);
            o.hsync       = !((x >= hd + hf) && (x < hd + hf + hs));
            o.vsync       = !((y >= vd + vf) && (y < vd + vf + vs));
            o.frame_start = ((e % div) == 0) && (p == 0);
        end
        o.x = 10'(x);
        o.y = 10'(y);
        return o;
    endfunction

    function automatic obs_t model_a(input int e);
        return model(e, 4, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction

    function automatic obs_t model_b(input int e);
        return model(e, 2, 8, 2, 2, 2, 4, 1, 1, 1);
    endfunction

    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s @%0t: got tick=%b x=%0d y=%0d von=%b hs=%b vs=%b fs=%b, want tick=%b x=%0d y=%0d von=%b hs=%b vs=%b fs=%b",
                     name, $time, act.p_tick, act.x, act.y, act.video_on, act.hsync, act.vsync, act.frame_start,
                     exp.p_tick, exp.x, exp.y, exp.video_on, exp.hsync, exp.vsync, exp.frame_start);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s @%0t: got %0d, want %0d", name, $time, act, exp);
        end
    endtask

    // Monitor A: scoreboard compare plus hsync low-run length (96 ticks * 4).
    int hs_run = 0;
    always begin
        obs_t exp;
        @(posedge clk);
        #1;
        if (q_a.size() > 0) begin
            exp = q_a.pop_front();
            check_obs("dut_a", {pt_a, x_a, y_a, von_a, hs_a, vs_a, fs_a}, exp);
        end
        if (hs_a === 1'b0) begin
            hs_run++;
        end else if (hs_run > 0) begin
            check_int("hsync_low_clks", hs_run, 384);
            hs_run = 0;
        end
    end

    // Monitor B: scoreboard compare plus frame_start spacing (7*14*2 clk).
    int cyc_b   = 0;
    int last_fs = -1;
    always begin
        obs_t exp;
        @(posedge clk);
        #1;
        cyc_b++;
        if (q_b.size() > 0) begin
            exp = q_b.pop_front();
            check_obs("dut_b", {pt_b, x_b, y_b, von_b, hs_b, vs_b, fs_b}, exp);
        end
        if (rst_b) begin
            last_fs = -1;
        end else if (fs_b) begin
            if (last_fs >= 0) check_int("frame_period", cyc_b - last_fs, 196);
            last_fs = cyc_b;
        end
    end

    task automatic drive_a();
        int   e = 0;
        int   hold = 0;
        bit   mid_done = 0;
        obs_t cur;
        for (int c = 0; c < 12000; c++) begin
            @(negedge clk);
            cur = model_a(e);
            // Reset for 2 clk, first reset edge being a tick edge at (300,1).
            if (!mid_done && !rst_a && cur.p_tick && cur.x == 10'd300 && cur.y == 10'd1) begin
                hold = 2;
                mid_done = 1;
            end
            rst_a = (c < 3) || (hold > 0);
            if (hold > 0) hold--;
            e = rst_a ? 0 : e + 1;
            q_a.push_back(model_a(e));
        end
        check_int("mid_line_reset_hit", int'(mid_done), 1);
    endtask

    task automatic drive_b();
        int   e = 0;
        int   hold = 0;
        bit   mid_done = 0;
        obs_t cur;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            cur = model_b(e);
            // After three clean frames: one tick-coincident mid-frame reset,
            // then sparse random resets of 1..3 clk.
            if (c > 700 && !mid_done && !rst_b && cur.p_tick && cur.x == 10'd5 && cur.y == 10'd3) begin
                hold = 2;
                mid_done = 1;
            end else if (c > 1000 && hold == 0 && $urandom_range(0, 149) == 0) begin
                hold = int'($urandom_range(1, 3));
            end
            rst_b = (c < 3) || (hold > 0);
            if (hold > 0) hold--;
            e = rst_b ? 0 : e + 1;
            q_b.push_back(model_b(e));
        end
        check_int("mid_frame_reset_hit", int'(mid_done), 1);
    endtask

    initial begin
        fork
            drive_a();
            drive_b();
        join
        repeat (3) @(posedge clk);
        #2;
        check_int("scoreboard_a_drained", q_a.size(), 0);
        check_int("scoreboard_b_drained", q_b.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

VGA timing generator for the RTC display pipeline. It divides the system clock into a pixel-rate enable and runs horizontal and vertical counters. From these it produces `pix_x`, `pix_y`, `video_on`, `hsync` and `vsync`, which all downstream overlay stages (digits, date bars, hour separators) consume. It is the first stage of the video path; every overlay samples its coordinates from this block.

## Interface
- `H_DISPLAY`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_DISPLAY`, 480, visible lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `CLK_DIV`, 4, clk cycles per pixel; legal range ≥2 (100 MHz → 25 MHz)

Ports:
- `clk` in 1: system clock
- `reset` in 1: reset, synchronous, active-high; clock `clk`
- `p_tick` out 1: pixel enable, high one clk every `CLK_DIV` clks
- `pix_x` out 10: horizontal count, 0..H_TOTAL-1
- `pix_y` out 10: vertical count, 0..V_TOTAL-1
- `video_on` out 1: high when `pix_x` < H_DISPLAY and `pix_y` < V_DISPLAY
- `hsync` out 1: horizontal sync, active-low
- `vsync` out 1: vertical sync, active-low
- `frame_start` out 1: one-clk pulse when the counts become (0,0)

## Operation
- Derived constants:
  - H_TOTAL = sum of the four H parameters (800).
  - V_TOTAL = sum of the four V parameters (525).
  - Both totals must be ≤1024.
- Divider:
  - Register `d`, width clog2(CLK_DIV).
  - Counts 0..CLK_DIV-1 and wraps.
  - `p_tick` = (`d` == CLK_DIV-1), decoded from the register.
- Horizontal counter:
  - Advances only on a clk edge where `p_tick` is high.
  - At H_TOTAL-1 it wraps to 0.
- Vertical counter:
  - Increments only when the horizontal counter wraps.
  - At V_TOTAL-1 it wraps to 0.
- Output decoding. `video_on`, `hsync`, `vsync` and `frame_start` are registers loaded on the same edge as the counters, from the counters' next values, so they always match `pix_x`/`pix_y`:
  - `hsync` = 0 iff next x ∈ [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] = [656, 751].
  - `vsync` = 0 iff next y ∈ [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] = [490, 491].
  - `frame_start` = 1 for exactly the one clk following the edge on which the counts wrap to (0,0); 0 otherwise, including clks without `p_tick`.
- Reset values, applied on any clk with `reset` high. Reset has priority over `p_tick`, including mid-line and mid-frame.
  - `d` = 0
  - `pix_x` = H_TOTAL-1 (799)
  - `pix_y` = V_TOTAL-1 (524)
  - `hsync` = 1, `vsync` = 1
  - `video_on` = 0, `frame_start` = 0
  - `p_tick` = 0 (follows from `d` = 0)
  - Consequence: the first `p_tick` after reset wraps the counts to (0,0) and starts a clean frame.

## Timing
- First `p_tick` after reset: on clk number CLK_DIV after `reset` deasserts (cycle 4 with the defaults).
- On the following clk:
  - `pix_x` = 0, `pix_y` = 0
  - `video_on` = 1, `frame_start` = 1
- Period between consecutive `p_tick`s: exactly CLK_DIV clks.
- Counter and decoded outputs hold stable for CLK_DIV clks between ticks.
- Line period: 800 ticks = 3200 clk.
- Frame period: 525 lines = 420,000 ticks = 1,680,000 clk.
- `hsync` low window: 96 ticks. `vsync` low window: 2 lines = 1600 ticks.
- Latency from counts to decoded outputs: 0; they change on the same edge.
- Downstream overlay stages register their RGB one clk later and are responsible for their own sync alignment.

## Structure
- Shared constants go in package `vga_timing_pkg`:
  - H_/V_ DISPLAY, FRONT, SYNC, BACK defaults
  - Derived H_TOTAL, V_TOTAL
  - HSYNC_START/END, VSYNC_START/END
  - 10-bit coordinate width
- The overlay modules read the visible extents from this package.
- One sub-module: `pixel_tick_gen`, the parameterised divider producing `p_tick`, reused by other pixel-rate blocks.
- Counters and decode stay in the top module.

## Test plan
- Reset, then release:
  - During reset: `pix_x`=799, `pix_y`=524, `hsync`=`vsync`=1, `video_on`=0, `p_tick`=0.
  - `p_tick` first high on the 4th clk after release.
  - Next clk: (0,0), `video_on`=1, `frame_start`=1 for one clk only.
- Horizontal line:
  - `video_on` falls when `pix_x` goes 639→640.
  - `hsync` falls at 655→656 and rises at 751→752; low for 384 clk.
  - `pix_x` wraps 799→0 and `pix_y` increments by 1 on the same edge.
- Vertical frame:
  - `vsync` is low only for `pix_y` 490–491.
  - `video_on` stays 0 for all `pix_y` ≥ 480.
  - `pix_y` wraps 524→0.
  - `frame_start` pulses are exactly 1,680,000 clk apart.
- Reset mid-frame at (300,200) for 2 clk, coinciding with a `p_tick`:
  - Reset values appear on the first reset edge; the tick is ignored.
  - Restart sequence is identical to the first scenario.
- Parameter override CLK_DIV=2, H 8/2/2/2, V 4/1/1/1:
  - `p_tick` every 2 clk.
  - `hsync` low at x=10–11, `vsync` low at y=5.
  - Line = 14 ticks, frame = 7 lines = 196 clk.
- Continuous run of 3 frames:
  - Check that `hsync` occurs once per line and `vsync` once per frame.
  - Check that `video_on` is never high outside 640×480.
